// File: rtl/bram_snap_capture.sv
// Snapshot writer for the fabric port of a dual-port BRAM: once armed and
// triggered it streams qualified samples to addresses 0..len-1, then flags done.
module bram_snap_capture #(
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 8
) (
    input  logic                      fabric_clk,
    input  logic                      fabric_rst_n,
    input  logic                      arm,
    input  logic                      trigger,
    input  logic [RAM_DATA_WIDTH-1:0] din,
    input  logic                      din_valid,
    input  logic [RAM_ADDR_WIDTH:0]   capture_len,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_data,
    output logic                      busy,
    output logic                      done,
    output logic [RAM_ADDR_WIDTH:0]   sample_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [RAM_ADDR_WIDTH:0] DEPTH = (RAM_ADDR_WIDTH+1)'(1) << RAM_ADDR_WIDTH;

    logic [1:0]                state;
    logic [RAM_ADDR_WIDTH:0]   len_r;
    logic [RAM_ADDR_WIDTH:0]   next_count;
    logic                      accept;
    logic                      arm_ok;

    assign next_count = sample_count + 1'b1;
    assign accept     = din_valid && ((state == ARMED && trigger) || state == CAPTURE);
    assign arm_ok     = arm && (state == IDLE || state == DONE);

    always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
        if (!fabric_rst_n) begin
            state        <= IDLE;
            len_r        <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_count <= '0;
        end else begin
            ram_we <= 1'b0;
            if (arm_ok) begin
                state        <= ARMED;
                busy         <= 1'b1;
                done         <= 1'b0;
                sample_count <= '0;
                // Zero or oversize lengths mean "fill the whole RAM".
                len_r        <= (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;
            end else if (accept) begin
                // sample_count < len_r <= DEPTH here, so its low bits are a valid address.
                ram_we       <= 1'b1;
                ram_addr     <= sample_count[RAM_ADDR_WIDTH-1:0];
                ram_data     <= din;
                sample_count <= next_count;
                if (next_count == len_r) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= CAPTURE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_snap_capture.sv
// Directed self-checking bench for bram_snap_capture: every check compares the
// full output vector {we,addr,data,busy,done,count} against hand-derived values.
module tb_bram_snap_capture;

    logic       fabric_clk = 1'b0;
    logic       fabric_rst_n;
    logic       arm, trigger, din_valid;
    logic [7:0] din;
    logic [8:0] capture_len;
    logic       ram_we, busy, done;
    logic [7:0] ram_addr, ram_data;
    logic [8:0] sample_count;

    int errors = 0;
    int checks = 0;

    bram_snap_capture #(.RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(8)) dut (
        .fabric_clk(fabric_clk), .fabric_rst_n(fabric_rst_n),
        .arm(arm), .trigger(trigger), .din(din), .din_valid(din_valid),
        .capture_len(capture_len), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .busy(busy), .done(done), .sample_count(sample_count)
    );

    always #5 fabric_clk = ~fabric_clk;

    task automatic tick();
        @(posedge fabric_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic we, input logic [7:0] addr,
                       input logic [7:0] data, input logic bsy, input logic dn,
                       input logic [8:0] cnt);
        logic [27:0] obs, exp;
        obs = {ram_we, ram_addr, ram_data, busy, done, sample_count};
        exp = {we, addr, data, bsy, dn, cnt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={we,addr,data,busy,done,cnt}=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fabric_rst_n = 1'b0;
        arm = 0; trigger = 0; din_valid = 0; din = 0; capture_len = 0;

        // Reset held with inputs toggling: everything stays zero, no writes.
        for (int i = 0; i < 12; i++) begin
            arm         = 1'($urandom);
            trigger     = 1'($urandom);
            din_valid   = 1'($urandom);
            din         = 8'($urandom);
            capture_len = 9'($urandom);
            tick();
            chk("reset_hold", 0, 8'h00, 8'h00, 0, 0, 9'd0);
        end
        arm = 0; trigger = 0; din_valid = 0; din = 0; capture_len = 0;
        #3 fabric_rst_n = 1'b1;
        tick();
        chk("post_reset_idle", 0, 8'h00, 8'h00, 0, 0, 9'd0);

        // Trigger in IDLE is ignored.
        trigger = 1; din_valid = 1; din = 8'h55;
        tick();
        chk("idle_trigger_ignored", 0, 8'h00, 8'h00, 0, 0, 9'd0);
        trigger = 0; din_valid = 0;

        // Basic capture of 4 continuous samples.
        capture_len = 9'd4; arm = 1;
        tick(); arm = 0;
        chk("basic_armed", 0, 8'h00, 8'h00, 1, 0, 9'd0);
        trigger = 1; din_valid = 1; din = 8'hA0;
        tick(); trigger = 0;
        chk("basic_w0", 1, 8'd0, 8'hA0, 1, 0, 9'd1);
        din = 8'hA1; tick();
        chk("basic_w1", 1, 8'd1, 8'hA1, 1, 0, 9'd2);
        din = 8'hA2; tick();
        chk("basic_w2", 1, 8'd2, 8'hA2, 1, 0, 9'd3);
        din = 8'hA3; tick();
        chk("basic_w3_done", 1, 8'd3, 8'hA3, 0, 1, 9'd4);
        din = 8'hEE; tick();
        chk("basic_hold", 0, 8'd3, 8'hA3, 0, 1, 9'd4);
        din_valid = 0;

        // Gapped valid, re-armed from DONE: valid pattern 1,0,0,1,0,1.
        capture_len = 9'd3; arm = 1;
        tick(); arm = 0;
        chk("gap_armed_done_clr", 0, 8'd3, 8'hA3, 1, 0, 9'd0);
        trigger = 1; din_valid = 1; din = 8'hB0;
        tick(); trigger = 0; din_valid = 0; din = 8'hFF;
        chk("gap_w0", 1, 8'd0, 8'hB0, 1, 0, 9'd1);
        tick();
        chk("gap_idle1", 0, 8'd0, 8'hB0, 1, 0, 9'd1);
        tick();
        chk("gap_idle2", 0, 8'd0, 8'hB0, 1, 0, 9'd1);
        din_valid = 1; din = 8'hB1;
        tick(); din_valid = 0; din = 8'hFE;
        chk("gap_w1", 1, 8'd1, 8'hB1, 1, 0, 9'd2);
        tick();
        chk("gap_idle3", 0, 8'd1, 8'hB1, 1, 0, 9'd2);
        din_valid = 1; din = 8'hB2;
        tick(); din_valid = 0;
        chk("gap_w2_done", 1, 8'd2, 8'hB2, 0, 1, 9'd3);

        // Trigger in DONE is ignored.
        trigger = 1; din_valid = 1; din = 8'h11;
        tick();
        chk("done_trigger_ignored", 0, 8'd2, 8'hB2, 0, 1, 9'd3);

        // Arm+trigger+valid together: only arm; trigger w/o valid ignored; arm during capture ignored.
        capture_len = 9'd2; arm = 1;
        tick(); arm = 0; din_valid = 0;
        chk("arm_trig_same_cycle", 0, 8'd2, 8'hB2, 1, 0, 9'd0);
        tick();
        chk("trig_no_valid", 0, 8'd2, 8'hB2, 1, 0, 9'd0);
        din_valid = 1; din = 8'hC0;
        tick(); trigger = 0; din_valid = 0;
        chk("trig_w0", 1, 8'd0, 8'hC0, 1, 0, 9'd1);
        arm = 1; capture_len = 9'd5;
        tick(); arm = 0;
        chk("arm_in_capture", 0, 8'd0, 8'hC0, 1, 0, 9'd1);
        din_valid = 1; din = 8'hC1;
        tick(); din_valid = 0;
        chk("trig_w1_done", 1, 8'd1, 8'hC1, 0, 1, 9'd2);

        // Length 1: trigger sample alone completes the snapshot.
        capture_len = 9'd1; arm = 1;
        tick(); arm = 0;
        trigger = 1; din_valid = 1; din = 8'hD0;
        tick(); trigger = 0;
        chk("len1_done", 1, 8'd0, 8'hD0, 0, 1, 9'd1);
        din = 8'hD1; tick(); din_valid = 0;
        chk("len1_no_more", 0, 8'd0, 8'hD0, 0, 1, 9'd1);

        // Full depth via capture_len=0, continuous valid.
        capture_len = 9'd0; arm = 1;
        tick(); arm = 0;
        chk("full_armed", 0, 8'd0, 8'hD0, 1, 0, 9'd0);
        trigger = 1; din_valid = 1;
        for (int i = 0; i < 256; i++) begin
            din = 8'(i ^ 8'h5A);
            tick(); trigger = 0;
            chk("full_wr", 1, 8'(i), 8'(i ^ 8'h5A), (i != 255), (i == 255), 9'(i + 1));
        end
        din = 8'h00; tick();
        chk("full_no_wrap", 0, 8'd255, 8'(255 ^ 8'h5A), 0, 1, 9'd256);
        din_valid = 0;

        // Oversize length also clamps to DEPTH: still busy after 200 writes.
        capture_len = 9'd300; arm = 1;
        tick(); arm = 0;
        trigger = 1; din_valid = 1;
        for (int i = 0; i < 200; i++) begin
            din = 8'(i); tick(); trigger = 0;
        end
        din_valid = 0;
        chk("oversize_clamp", 1, 8'd199, 8'd199, 1, 0, 9'd200);
        tick();

        // Reset mid-capture, outputs clear without a clock edge.
        fabric_rst_n = 1'b0; #2; fabric_rst_n = 1'b1; tick();
        capture_len = 9'd8; arm = 1;
        tick(); arm = 0;
        trigger = 1; din_valid = 1;
        din = 8'hE0; tick(); trigger = 0;
        chk("rst_w0", 1, 8'd0, 8'hE0, 1, 0, 9'd1);
        din = 8'hE1; tick();
        din = 8'hE2; tick();
        chk("rst_w2", 1, 8'd2, 8'hE2, 1, 0, 9'd3);
        #2 fabric_rst_n = 1'b0;
        #1 chk("rst_async_clear", 0, 8'd0, 8'd0, 0, 0, 9'd0);
        din_valid = 0;
        tick();
        chk("rst_held", 0, 8'd0, 8'd0, 0, 0, 9'd0);
        #2 fabric_rst_n = 1'b1;
        capture_len = 9'd2; arm = 1;
        tick(); arm = 0;
        trigger = 1; din_valid = 1; din = 8'hF0;
        tick(); trigger = 0;
        chk("rearm_w0", 1, 8'd0, 8'hF0, 1, 0, 9'd1);
        din = 8'hF1; tick(); din_valid = 0;
        chk("rearm_w1_done", 1, 8'd1, 8'hF1, 0, 1, 9'd2);
        arm = 1; tick(); arm = 0;
        chk("rearm_done_clears", 0, 8'd1, 8'hF1, 1, 0, 9'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
